// File: rtl/dll_lock_seq_if.sv
// DLL lock sequencer handshake bundle.
// Controller side drives start/stop/comp; sequencer returns code and status.
interface dll_lock_seq_if #(
  parameter int CODE_W = 10
);
  logic              start;
  logic              stop;
  logic              comp;
  logic [CODE_W-1:0] code;
  logic              pd_reset;
  logic              busy;
  logic              locked;
  logic              lock_lost;

  modport master (
    output start, stop, comp,
    input  code, pd_reset, busy, locked, lock_lost
  );

  modport slave (
    input  start, stop, comp,
    output code, pd_reset, busy, locked, lock_lost
  );
endinterface

// File: rtl/dll_lock_seq.sv
// Fast-lock DLL sequencer: SAR coarse search then up/down tracking.
// Declares lock after repeated reversals, restarts search on lock loss.
module dll_lock_seq #(
  parameter int CODE_W     = 10,
  parameter int SETTLE_CYC = 8,
  parameter int LOCK_CNT   = 4,
  parameter int LOSS_CNT   = 8
) (
  input  logic          clk_ext,
  input  logic          rst,
  dll_lock_seq_if.slave bus
);

  localparam int BW = $clog2(CODE_W);
  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int AW = $clog2(LOCK_CNT + 1);
  localparam int LW = $clog2(LOSS_CNT + 1);

  localparam logic [CODE_W-1:0] MID  = {1'b1, {(CODE_W-1){1'b0}}};
  localparam logic [CODE_W-1:0] MAXC = {CODE_W{1'b1}};
  localparam logic [BW-1:0]     TOPB = BW'(CODE_W - 1);
  localparam logic [SW-1:0]     SLST = SW'(SETTLE_CYC - 1);
  localparam logic [AW-1:0]     ALIM = AW'(LOCK_CNT);
  localparam logic [LW-1:0]     LLIM = LW'(LOSS_CNT);

  typedef enum logic [1:0] {IDLE, PD_RST, SETTLE, DECIDE} state_t;
  typedef enum logic {SEARCH, TRACK} mode_t;

  state_t            state_q, state_d;
  mode_t             mode_q, mode_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [BW-1:0]     bit_q, bit_d, bit_m1;
  logic [SW-1:0]     set_q, set_d;
  logic [AW-1:0]     alt_q, alt_d;
  logic [LW-1:0]     same_q, same_d;
  logic              dir_q, dir_d;
  logic              prev_q, prev_d;
  logic              locked_q, locked_d;
  logic              lost_q, lost_d;

  assign bit_m1 = bit_q - 1'b1;

  // Next-state, code update and lock bookkeeping
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    code_d   = code_q;
    bit_d    = bit_q;
    set_d    = set_q;
    alt_d    = alt_q;
    same_d   = same_q;
    dir_d    = dir_q;
    prev_d   = prev_q;
    locked_d = locked_q;
    lost_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          code_d  = MID;
          mode_d  = SEARCH;
          bit_d   = TOPB;
          alt_d   = '0;
          same_d  = '0;
          prev_d  = 1'b0;
          state_d = PD_RST;
        end
      end
      PD_RST: begin
        set_d   = '0;
        state_d = SETTLE;
      end
      SETTLE: begin
        if (set_q == SLST) begin
          state_d = DECIDE;
        end else begin
          set_d = set_q + 1'b1;
        end
      end
      DECIDE: begin
        state_d = PD_RST;
        if (mode_q == SEARCH) begin
          code_d[bit_q] = bus.comp;
          if (bit_q != '0) begin
            code_d[bit_m1] = 1'b1;
            bit_d          = bit_m1;
          end else begin
            mode_d = TRACK;
            alt_d  = '0;
            same_d = '0;
            prev_d = 1'b0;
          end
        end else begin
          if (bus.comp) begin
            if (code_q != MAXC) code_d = code_q + 1'b1;
          end else begin
            if (code_q != '0) code_d = code_q - 1'b1;
          end
          if (prev_q) begin
            if (bus.comp == dir_q) begin
              alt_d = '0;
              if (same_q != LLIM) same_d = same_q + 1'b1;
            end else begin
              same_d = '0;
              if (alt_q != ALIM) alt_d = alt_q + 1'b1;
            end
          end
          dir_d  = bus.comp;
          prev_d = 1'b1;
          if (alt_d == ALIM) locked_d = 1'b1;
          if (locked_q && same_d == LLIM) begin
            lost_d   = 1'b1;
            locked_d = 1'b0;
            code_d   = MID;
            mode_d   = SEARCH;
            bit_d    = TOPB;
            alt_d    = '0;
            same_d   = '0;
            prev_d   = 1'b0;
          end
        end
      end
    endcase
    if (bus.stop) begin
      state_d  = IDLE;
      mode_d   = mode_q;
      code_d   = code_q;
      bit_d    = bit_q;
      set_d    = '0;
      alt_d    = '0;
      same_d   = '0;
      prev_d   = 1'b0;
      locked_d = 1'b0;
      lost_d   = 1'b0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk_ext) begin
    if (rst) begin
      state_q  <= IDLE;
      mode_q   <= SEARCH;
      code_q   <= '0;
      bit_q    <= TOPB;
      set_q    <= '0;
      alt_q    <= '0;
      same_q   <= '0;
      dir_q    <= 1'b0;
      prev_q   <= 1'b0;
      locked_q <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      code_q   <= code_d;
      bit_q    <= bit_d;
      set_q    <= set_d;
      alt_q    <= alt_d;
      same_q   <= same_d;
      dir_q    <= dir_d;
      prev_q   <= prev_d;
      locked_q <= locked_d;
      lost_q   <= lost_d;
    end
  end

  assign bus.code      = code_q;
  assign bus.pd_reset  = (state_q == PD_RST);
  assign bus.busy      = (state_q != IDLE);
  assign bus.locked    = locked_q;
  assign bus.lock_lost = lost_q;

endmodule

// File: tb/tb_dll_lock_seq.sv
// Bench for dll_lock_seq: PD model, scoreboard of codes seen at pd_reset,
// table of search targets plus hand-written abort/loss/reset sequences.
module tb_dll_lock_seq;

  logic clk = 1'b0;
  logic rst;
  int   target;
  int   code_i;

  always #5 clk = ~clk;

  dll_lock_seq_if #(.CODE_W(10)) bus ();

  dll_lock_seq #(
    .CODE_W(10), .SETTLE_CYC(8), .LOCK_CNT(4), .LOSS_CNT(8)
  ) dut (
    .clk_ext(clk),
    .rst(rst),
    .bus(bus)
  );

  assign code_i   = int'(bus.code);
  assign bus.comp = (code_i <= target);

  typedef struct {
    logic [9:0] code;
    logic       locked;
    logic       lost;
    logic       gap;
  } exp_t;

  typedef struct {
    int target;
    int fin;
    bit lock;
  } vec_t;

  exp_t q[$];
  vec_t vecs[6];
  int   n_chk = 0;
  int   n_fail = 0;
  int   gap = 0;
  int   lost_cyc = 0;
  int   pd_cnt = 0;

  task automatic check(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int trial(int t, int k);
    int b;
    b = (t < 0) ? 0 : t;
    return (b & ~((1 << (10 - k)) - 1)) | (1 << (9 - k));
  endfunction

  task automatic push(int c, bit lk, bit lo, bit g);
    exp_t e;
    e.code   = 10'(c);
    e.locked = lk;
    e.lost   = lo;
    e.gap    = g;
    q.push_back(e);
  endtask

  task automatic push_search(int t, bit after_loss, int steps);
    for (int k = 0; k < steps; k++)
      push(trial(t, k), 1'b0, after_loss && k == 0, after_loss || k != 0);
  endtask

  task automatic push_track(int fin, bit alt);
    for (int k = 0; k < 8; k++)
      push(alt ? fin + (k & 1) : fin, alt && k >= 5, 1'b0, 1'b1);
  endtask

  // Scoreboard: every pd_reset marks a new step whose code is compared
  always @(negedge clk) begin
    exp_t e;
    gap++;
    if (bus.lock_lost) lost_cyc++;
    if (bus.pd_reset) begin
      pd_cnt++;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("step_code", code_i, int'(e.code));
        check("step_locked", int'(bus.locked), int'(e.locked));
        check("step_lost", int'(bus.lock_lost), int'(e.lost));
        check("step_busy", int'(bus.busy), 1);
        if (e.gap) check("step_period", gap, 10);
      end
      gap = 0;
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    tick(2);
    rst = 1'b0;
    q.delete();
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_empty(int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain", q.size(), 0);
  endtask

  task automatic check_reset_outs(string nm);
    check({nm, "_code"}, code_i, 0);
    check({nm, "_busy"}, int'(bus.busy), 0);
    check({nm, "_locked"}, int'(bus.locked), 0);
    check({nm, "_pd_reset"}, int'(bus.pd_reset), 0);
    check({nm, "_lock_lost"}, int'(bus.lock_lost), 0);
  endtask

  initial begin
    int pd0;
    vecs[0] = '{700, 700, 1'b1};
    vecs[1] = '{333, 333, 1'b1};
    vecs[2] = '{0, 0, 1'b1};
    vecs[3] = '{1023, 1023, 1'b0};
    vecs[4] = '{-1, 0, 1'b0};
    vecs[5] = '{100, 100, 1'b1};
    target    = 700;
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.stop  = 1'b0;
    tick(2);
    check_reset_outs("rst_hold");
    bus.start = 1'b0;
    rst       = 1'b0;
    tick();
    check_reset_outs("rst_release");

    foreach (vecs[i]) begin
      do_reset();
      target = vecs[i].target;
      push_search(target, 1'b0, 10);
      push_track(vecs[i].fin, vecs[i].lock);
      lost_cyc = 0;
      pulse_start();
      tick(3);
      pulse_start();
      wait_empty(400);
      check("vec_busy", int'(bus.busy), 1);
      check("vec_lock", int'(bus.locked), int'(vecs[i].lock));
      check("vec_no_loss", lost_cyc, 0);
    end

    do_reset();
    target = 700;
    push_search(700, 1'b0, 10);
    push_track(700, 1'b1);
    pulse_start();
    wait_empty(400);
    check("loss_pre_locked", int'(bus.locked), 1);
    target = 100;
    for (int i = 0; i < 8; i++) push(700 - i, 1'b1, 1'b0, 1'b1);
    push_search(100, 1'b1, 10);
    push_track(100, 1'b1);
    lost_cyc = 0;
    wait_empty(600);
    check("loss_pulse_len", lost_cyc, 1);
    check("relock", int'(bus.locked), 1);

    do_reset();
    target = 700;
    push_search(700, 1'b0, 5);
    pulse_start();
    wait_empty(100);
    tick(3);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    check("stop_busy", int'(bus.busy), 0);
    check("stop_code", code_i, trial(700, 4));
    check("stop_locked", int'(bus.locked), 0);
    pd0 = pd_cnt;
    tick(15);
    check("stop_idle_pd", pd_cnt, pd0);
    check("stop_idle_code", code_i, trial(700, 4));
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    check("startstop_busy", int'(bus.busy), 0);
    tick(12);
    check("startstop_pd", pd_cnt, pd0);
    check("startstop_code", code_i, trial(700, 4));

    do_reset();
    target = 333;
    push_search(333, 1'b0, 10);
    push_track(333, 1'b1);
    pulse_start();
    wait_empty(400);
    check("track_locked", int'(bus.locked), 1);
    rst = 1'b1;
    tick();
    check_reset_outs("rst_track");
    rst = 1'b0;
    tick(2);
    check("rst_stays_idle", int'(bus.busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dll_lock_seq.md
Name: dll_lock_seq

Overview:
Lock sequencer for the delay-line tuning path of the fast-lock DLL. It drives the 10-bit delay code through a binary (SAR) coarse search, then an up/down fine-tracking phase, using the phase-detector compare bit. It also issues the phase-detector reset between steps, declares lock and lock loss, and restarts the search on lock loss. It sits between the phase detector and the 4-to-16 thermometer decoder, which takes code[9:6].

Parameters:
CODE_W, 10, delay code width
SETTLE_CYC, 8, cycles waited after each code change before comp is sampled (min 1)
LOCK_CNT, 4, consecutive direction reversals in tracking needed to assert locked
LOSS_CNT, 8, consecutive same-direction tracking steps while locked that declare lock loss

Ports:
clk_ext  in  1  reference clock; all logic on its rising edge
rst  in  1  reset, synchronous, active-high
start  in  1  begin acquisition; one-cycle pulse; ignored while busy=1
stop  in  1  abort to IDLE; code held
comp  in  1  PD result; 1 = delay too short (increase code), 0 = too long
code  out  CODE_W  delay code to the delay line / decoder
pd_reset  out  1  PD reset strobe, high for exactly the PD_RST cycle
busy  out  1  high in every state except IDLE
locked  out  1  lock indication
lock_lost  out  1  one-cycle pulse on detected lock loss

Behaviour:
- Reset (rst=1 at an edge): state IDLE, code=0, pd_reset=0, busy=0, locked=0, lock_lost=0, bit index=CODE_W-1, all counters 0. rst overrides start and stop.
- States: IDLE, PD_RST, SETTLE, DECIDE. A mode flag selects SEARCH or TRACK.
- IDLE:
  - start=1: code <= 1<<(CODE_W-1) (512), mode=SEARCH, bit index=CODE_W-1, then go to PD_RST.
- PD_RST: pd_reset=1 for 1 cycle, then SETTLE.
- SETTLE: stay exactly SETTLE_CYC cycles, then DECIDE.
- DECIDE: comp is sampled for 1 cycle; the code update is registered at the end of this cycle; next state is PD_RST.
  - One step = 1+SETTLE_CYC+1 cycles (10 at defaults).
- SEARCH decision at bit b:
  - comp=0: clear bit b; comp=1: keep bit b.
  - If b>0, also set bit b-1 and decrement b.
  - If b=0, switch to TRACK and clear both counters.
  - Full search = CODE_W steps (100 cycles at defaults from the first PD_RST).
- TRACK decision:
  - comp=1: code+1, saturating at 2^CODE_W-1. comp=0: code-1, saturating at 0. A saturated step still counts as that direction.
  - Direction same as previous step: same_cnt++, alt_cnt=0.
  - Direction differs: alt_cnt++, same_cnt=0.
  - First TRACK step has no previous direction; it counts as neither.
- Counters saturate at their thresholds.
- locked:
  - Set in the cycle after the DECIDE in which alt_cnt reaches LOCK_CNT.
  - Stays high through tracking until lock loss, stop, or rst.
- Lock loss:
  - While locked=1, same_cnt reaching LOSS_CNT pulses lock_lost for 1 cycle and clears locked.
  - It also reloads code=512, mode=SEARCH, b=CODE_W-1, and proceeds to PD_RST, so re-acquisition is automatic.
  - same_cnt reaching LOSS_CNT while unlocked has no effect.
- stop=1 (rst=0), any state:
  - Next state IDLE; code held; locked=0; pd_reset=0; counters cleared.
  - stop takes priority over start in the same cycle.
- start while busy: ignored, no side effects.
- comp is sampled only in DECIDE; its value in other cycles is don't-care.

Test Plan:
- Reset: hold rst 2 cycles with start=1 -> code=0, busy=0, locked=0, pd_reset=0, lock_lost=0; no state change.
- Search convergence: PD model comp=(code<=700), start pulse -> pd_reset pulses every 10 cycles; code sequence 512,768,640,704,672,688,696,700,702,701 at DECIDE; final search code 700; busy=1; mode TRACK.
- Lock: after the previous case the model yields alternating comp -> code toggles 701/700; locked rises after the 4th reversal; lock_lost stays 0.
- Lock loss and relock: while locked, switch model target to 100 -> 8 consecutive decrements; lock_lost one-cycle pulse; locked=0; code reloads 512; search re-converges to 100; locked returns.
- Saturation: comp tied 1 -> search ends at 1023; tracking holds 1023; locked never asserts. comp tied 0 -> search ends at 0, holds 0.
- Abort and priority:
  - stop mid-search at step 5 -> IDLE next cycle, code held, busy=0.
  - start+stop same cycle -> stays IDLE.
  - rst mid-TRACK -> all outputs to reset values next cycle.
